// File: rtl/capp_pkg.sv
// capp_pkg: shared types for the CAPP array (opcodes and control FSM states).
package capp_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [2:0] {
        OpNop         = 3'd0,
        OpSetAll      = 3'd1,
        OpSearch      = 3'd2,
        OpSearchAnd   = 3'd3,
        OpWrite       = 3'd4,
        OpRead        = 3'd5,
        OpSelectFirst = 3'd6,
        OpClearTags   = 3'd7
    } capp_op_e;

    // Command sequencing: accept, execute for one cycle, hold the response.
    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } capp_state_e;

endpackage

// File: rtl/capp_first_responder.sv
// capp_first_responder: combinational priority resolver. Keeps only the
// lowest-index set bit of the tag vector; an all-zero input gives zero.
module capp_first_responder #(
    parameter int unsigned NUM_CELLS = 100
) (
    input  logic [NUM_CELLS-1:0] tags_i,
    output logic [NUM_CELLS-1:0] first_o
);

    logic found;

    // Scan upward; the first set tag wins and masks all later ones.
    always_comb begin
        first_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (tags_i[i] && !found) begin
                first_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/capp_array.sv
// capp_array: content-addressable parallel processor array with a per-cell tag
// register, driven over a valid/ready command channel with one response per
// command. Optional feature macro: CAPP_RESP_COUNT_EN enables the registered
// responder popcount on rsp_count; without it rsp_count is tied to zero.
module capp_array
    import capp_pkg::*;
#(
    parameter int unsigned NUM_BITS  = 32,
    parameter int unsigned NUM_CELLS = 100,
    localparam int unsigned CNT_W    = $clog2(NUM_CELLS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [NUM_BITS-1:0]  cmd_comparand,
    input  logic [NUM_BITS-1:0]  cmd_mask,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [NUM_BITS-1:0]  rsp_data,
    output logic                 rsp_some,
    output logic [CNT_W-1:0]     rsp_count,
    output logic [NUM_CELLS-1:0] tags
);

    capp_state_e          state_q;
    capp_op_e             op_q;
    logic [NUM_BITS-1:0]  comp_q;
    logic [NUM_BITS-1:0]  mask_q;
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic [NUM_BITS-1:0]  rsp_data_q;
    logic                 rsp_some_q;
    logic [CNT_W-1:0]     rsp_count_q;

    logic [NUM_BITS-1:0]  store_q [NUM_CELLS];
    logic [NUM_BITS-1:0]  store_d [NUM_CELLS];
    logic [NUM_CELLS-1:0] tags_q;
    logic [NUM_CELLS-1:0] tags_d;
    logic [NUM_CELLS-1:0] match;
    logic [NUM_CELLS-1:0] first;

    logic [NUM_BITS-1:0]  rsp_data_d;
    logic [CNT_W-1:0]     rsp_count_d;

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_some  = rsp_some_q;
    assign rsp_count = rsp_count_q;
    assign tags      = tags_q;

    // Masked compare of every cell against the latched comparand.
    always_comb begin
        for (int i = 0; i < NUM_CELLS; i++) begin
            match[i] = (((store_q[i] ^ comp_q) & mask_q) == '0);
        end
    end

    capp_first_responder #(
        .NUM_CELLS (NUM_CELLS)
    ) u_first_responder (
        .tags_i  (tags_q),
        .first_o (first)
    );

    // Post-operation tags and storage for the latched command.
    always_comb begin
        tags_d  = tags_q;
        store_d = store_q;
        case (op_q)
            OpSetAll:      tags_d = '1;
            OpSearch:      tags_d = match;
            OpSearchAnd:   tags_d = tags_q & match;
            OpWrite: begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (tags_q[i]) begin
                        store_d[i] = (store_q[i] & ~mask_q) | (comp_q & mask_q);
                    end
                end
            end
            OpSelectFirst: tags_d = first;
            OpClearTags:   tags_d = '0;
            default:       ;
        endcase
    end

    // Wired-OR read of tagged words and optional responder count, post-operation.
    always_comb begin
        rsp_data_d = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            rsp_data_d = rsp_data_d | (store_d[i] & {NUM_BITS{tags_d[i]}});
        end
`ifdef CAPP_RESP_COUNT_EN
        rsp_count_d = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            rsp_count_d = rsp_count_d + CNT_W'(tags_d[i]);
        end
`else
        rsp_count_d = '0;
`endif
    end

    // Storage and tags commit only in the single execute cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tags_q <= '0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                store_q[i] <= '0;
            end
        end else if (state_q == StExec) begin
            tags_q <= tags_d;
            for (int i = 0; i < NUM_CELLS; i++) begin
                store_q[i] <= store_d[i];
            end
        end
    end

    // Command FSM with registered handshake and response outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            op_q        <= OpNop;
            comp_q      <= '0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_some_q  <= 1'b0;
            rsp_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q        <= capp_op_e'(cmd_op);
                        comp_q      <= cmd_comparand;
                        mask_q      <= cmd_mask;
                        cmd_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    rsp_data_q  <= rsp_data_d;
                    rsp_some_q  <= |tags_d;
                    rsp_count_q <= rsp_count_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    // Return to idle only; a new command waits one more cycle.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capp_array.sv
// tb_capp_array: directed vector table, hand sequences for stall/reset corner
// cases and randomized commands against a behavioural model of the array.
module tb_capp_array;

    localparam int unsigned NB = 32;
    localparam int unsigned NC = 100;
    localparam int unsigned CW = $clog2(NC + 1);
`ifdef CAPP_RESP_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    localparam logic [2:0] CmdNop         = 3'd0;
    localparam logic [2:0] CmdSetAll      = 3'd1;
    localparam logic [2:0] CmdSearch      = 3'd2;
    localparam logic [2:0] CmdSearchAnd   = 3'd3;
    localparam logic [2:0] CmdWrite       = 3'd4;
    localparam logic [2:0] CmdRead        = 3'd5;
    localparam logic [2:0] CmdSelectFirst = 3'd6;
    localparam logic [2:0] CmdClearTags   = 3'd7;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [NB-1:0] cmd_comparand;
    logic [NB-1:0] cmd_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [NB-1:0] rsp_data;
    logic          rsp_some;
    logic [CW-1:0] rsp_count;
    logic [NC-1:0] tags;

    capp_array #(
        .NUM_BITS  (NB),
        .NUM_CELLS (NC)
    ) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_comparand (cmd_comparand),
        .cmd_mask      (cmd_mask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_some      (rsp_some),
        .rsp_count     (rsp_count),
        .tags          (tags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Behavioural model: plain arrays updated by the opcode rules.
    logic [NB-1:0] m_store [NC];
    logic [NC-1:0] m_tags;

    typedef struct {
        logic [2:0]    op;
        logic [NB-1:0] comp;
        logic [NB-1:0] mask;
        logic [NB-1:0] data;
        logic          some;
        int            cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_tags = '0;
        for (int i = 0; i < NC; i++) m_store[i] = '0;
    endfunction

    function automatic void m_apply(input logic [2:0] op, input logic [NB-1:0] comp,
                                    input logic [NB-1:0] mask);
        case (op)
            CmdSetAll: m_tags = '1;
            CmdSearch: for (int i = 0; i < NC; i++) m_tags[i] = (((m_store[i] ^ comp) & mask) == '0);
            CmdSearchAnd: for (int i = 0; i < NC; i++)
                m_tags[i] = m_tags[i] & (((m_store[i] ^ comp) & mask) == '0);
            CmdWrite: for (int i = 0; i < NC; i++)
                if (m_tags[i]) m_store[i] = (m_store[i] & ~mask) | (comp & mask);
            // Two's-complement trick isolates the lowest set bit.
            CmdSelectFirst: m_tags = m_tags & (~m_tags + NC'(1));
            CmdClearTags: m_tags = '0;
            default: ;
        endcase
    endfunction

    function automatic logic [NB-1:0] m_data();
        logic [NB-1:0] d = '0;
        for (int i = 0; i < NC; i++) if (m_tags[i]) d = d | m_store[i];
        return d;
    endfunction

    function automatic logic [CW-1:0] m_count();
        return CountEn ? CW'($countones(m_tags)) : '0;
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [NB-1:0] comp,
                          input logic [NB-1:0] mask, input int stall,
                          output logic [NB-1:0] d, output logic s,
                          output logic [CW-1:0] c, output logic [NC-1:0] t);
        int            n;
        logic [NB-1:0] ed;
        logic [CW-1:0] ec;
        @(negedge clk);
        cmd_op        = op;
        cmd_comparand = comp;
        cmd_mask      = mask;
        cmd_valid     = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 128'(cmd_ready), 128'(1'b1));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("exec_cmd_ready", 128'(cmd_ready), 128'(1'b0));
        m_apply(op, comp, mask);
        ed = m_data();
        ec = m_count();
        @(negedge clk);
        check("resp_rsp_valid", 128'(rsp_valid), 128'(1'b1));
        for (int k = 0; k < stall; k++) begin
            check("stall_data", 128'(rsp_data), 128'(ed));
            @(negedge clk);
        end
        d = rsp_data;
        s = rsp_some;
        c = rsp_count;
        t = tags;
        check("model_data", 128'(rsp_data), 128'(ed));
        check("model_some", 128'(rsp_some), 128'(m_tags != '0));
        check("model_count", 128'(rsp_count), 128'(ec));
        check("model_tags", 128'(tags), 128'(m_tags));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ret_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    endtask

    // Hard bound on run time.
    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] d;
        logic          s;
        logic [CW-1:0] c;
        logic [NC-1:0] t;
        logic [NC-1:0] exp_t;

        vecs[0]  = '{CmdSetAll,      32'h0,        32'h0,        32'h0,        1'b1, 100};
        vecs[1]  = '{CmdWrite,       32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 100};
        vecs[2]  = '{CmdRead,        32'h0,        32'h0,        32'hA5A5A5A5, 1'b1, 100};
        vecs[3]  = '{CmdClearTags,   32'h0,        32'h0,        32'h0,        1'b0, 0};
        vecs[4]  = '{CmdSearch,      32'h0,        32'h0,        32'hA5A5A5A5, 1'b1, 100};
        vecs[5]  = '{CmdNop,         32'h0,        32'h0,        32'hA5A5A5A5, 1'b1, 100};
        vecs[6]  = '{CmdSearch,      32'hA5A5A5A5, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 100};
        vecs[7]  = '{CmdSearchAnd,   32'h0,        32'h1,        32'h0,        1'b0, 0};
        vecs[8]  = '{CmdRead,        32'h0,        32'h0,        32'h0,        1'b0, 0};
        vecs[9]  = '{CmdWrite,       32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 0};
        vecs[10] = '{CmdSetAll,      32'h0,        32'h0,        32'hA5A5A5A5, 1'b1, 100};
        vecs[11] = '{CmdWrite,       32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 100};
        vecs[12] = '{CmdSelectFirst, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vecs[13] = '{CmdClearTags,   32'h0,        32'h0,        32'h0,        1'b0, 0};
        vecs[14] = '{CmdSelectFirst, 32'h0,        32'h0,        32'h0,        1'b0, 0};

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_comparand = '0;
        cmd_mask = '0;
        rsp_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("rst_rsp_data", 128'(rsp_data), 128'(0));
        check("rst_rsp_some", 128'(rsp_some), 128'(1'b0));
        check("rst_rsp_count", 128'(rsp_count), 128'(0));
        check("rst_tags", 128'(tags), 128'(0));

        // Directed vector table.
        for (int v = 0; v < 15; v++) begin
            do_cmd(vecs[v].op, vecs[v].comp, vecs[v].mask, 0, d, s, c, t);
            check("vec_data", 128'(d), 128'(vecs[v].data));
            check("vec_some", 128'(s), 128'(vecs[v].some));
            check("vec_count", 128'(c), 128'(CountEn ? vecs[v].cnt : 0));
        end

        // Give cells 0..7 distinct labels using search/select-first/write.
        for (int i = 0; i < 8; i++) begin
            do_cmd(CmdSearch, 32'h0, 32'hFFFFFFFF, 0, d, s, c, t);
            do_cmd(CmdSelectFirst, 32'h0, 32'h0, 0, d, s, c, t);
            do_cmd(CmdWrite, NB'((i + 1) << 4), 32'hFFFFFFFF, 0, d, s, c, t);
        end
        do_cmd(CmdSearch, 32'h40, 32'hFFFFFFFF, 0, d, s, c, t);
        do_cmd(CmdWrite, 32'h1, 32'hFFFFFFFF, 0, d, s, c, t);
        do_cmd(CmdSearch, 32'h80, 32'hFFFFFFFF, 0, d, s, c, t);
        do_cmd(CmdWrite, 32'h1, 32'hFFFFFFFF, 0, d, s, c, t);
        do_cmd(CmdSearch, 32'h1, 32'h1, 0, d, s, c, t);
        exp_t = (NC'(1) << 3) | (NC'(1) << 7);
        check("search37_tags", 128'(t), 128'(exp_t));
        check("search37_count", 128'(c), 128'(CountEn ? 2 : 0));
        do_cmd(CmdSelectFirst, 32'h0, 32'h0, 0, d, s, c, t);
        exp_t = NC'(1) << 3;
        check("selfirst_tags", 128'(t), 128'(exp_t));
        check("selfirst_count", 128'(c), 128'(CountEn ? 1 : 0));
        do_cmd(CmdWrite, 32'h12345678, 32'hFFFFFFFF, 0, d, s, c, t);
        do_cmd(CmdWrite, 32'hFFFF0000, 32'h00FF00FF, 0, d, s, c, t);
        do_cmd(CmdRead, 32'h0, 32'h0, 0, d, s, c, t);
        check("masked_write", 128'(d), 128'(32'h12FF5600));
        do_cmd(CmdSearch, 32'h1, 32'hFFFFFFFF, 0, d, s, c, t);
        exp_t = NC'(1) << 7;
        check("cell7_tags", 128'(t), 128'(exp_t));
        check("cell7_data", 128'(d), 128'(32'h1));
        do_cmd(CmdSetAll, 32'h0, 32'h0, 0, d, s, c, t);
        check("or_all", 128'(d), 128'(32'h12FF5671));

        // Response stall with a second command held on the channel.
        @(negedge clk);
        cmd_op = CmdRead;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = CmdClearTags;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("hold_rsp_valid", 128'(rsp_valid), 128'(1'b1));
            check("hold_rsp_data", 128'(rsp_data), 128'(32'h12FF5671));
            check("hold_cmd_ready", 128'(cmd_ready), 128'(1'b0));
            check("hold_tags", 128'(tags), 128'(m_tags));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        check("back_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("back_tags", 128'(tags), 128'(m_tags));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("second_accepted", 128'(cmd_ready), 128'(1'b0));
        m_apply(CmdClearTags, 32'h0, 32'h0);
        @(negedge clk);
        check("second_rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check("second_tags", 128'(tags), 128'(m_tags));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset during the execute cycle of a write.
        do_cmd(CmdSetAll, 32'h0, 32'h0, 0, d, s, c, t);
        @(negedge clk);
        cmd_op = CmdWrite;
        cmd_comparand = 32'hDEADBEEF;
        cmd_mask = 32'hFFFFFFFF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_exec_ready", 128'(cmd_ready), 128'(1'b0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(rsp_valid), 128'(1'b0));
        check("mid_rst_tags", 128'(tags), 128'(0));
        check("mid_rst_ready", 128'(cmd_ready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        do_cmd(CmdSetAll, 32'h0, 32'h0, 0, d, s, c, t);
        check("post_rst_data", 128'(d), 128'(0));
        do_cmd(CmdRead, 32'h0, 32'h0, 0, d, s, c, t);
        check("post_rst_read", 128'(d), 128'(0));

        // Randomized commands against the model.
        for (int r = 0; r < 300; r++) begin
            do_cmd(3'($urandom_range(0, 7)), NB'($urandom),
                   NB'($urandom & $urandom & $urandom), $urandom_range(0, 2), d, s, c, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/capp_array.md
# capp_array

Next-generation content-addressable parallel processor (CAPP) array. It holds NUM_CELLS words of NUM_BITS bits each, plus a per-cell tag register. Operations arrive over a single valid/ready command channel and perform masked parallel search, tagged masked write, wired-OR read and first-responder selection. Every command produces exactly one response carrying the wired-OR read word, an any-responder flag and a responder count. It replaces the raw line-level cell array as the unit that the CAPP sequencer talks to.

## Interface
- NUM_BITS, 32, word width (≥1)
- NUM_CELLS, 100, number of words/tags (≥1)
- CNT_W, $clog2(NUM_CELLS+1), width of the responder count (localparam)

- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  array can accept a command
- cmd_op  in  3  opcode (see Operation)
- cmd_comparand  in  NUM_BITS  search key / write data
- cmd_mask  in  NUM_BITS  1 = bit participates in search/write
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  NUM_BITS  OR of all tagged words, post-operation
- rsp_some  out  1  any tag set, post-operation
- rsp_count  out  CNT_W  number of set tags, post-operation
- tags  out  NUM_CELLS  current tag register

## Operation
- Opcodes:
  - 0 NOP: no change.
  - 1 SET_ALL: all tags ← 1.
  - 2 SEARCH: tags ← match.
  - 3 SEARCH_AND: tags ← tags & match.
  - 4 WRITE: for each tagged cell, masked bits ← cmd_comparand; unmasked bits and untagged cells are unchanged; tags are unchanged.
  - 5 READ: no state change.
  - 6 SELECT_FIRST: keep only the lowest-index set tag.
  - 7 CLEAR_TAGS: all tags ← 0.
- Match rule: cell i matches iff every bit j with cmd_mask[j]=1 has store[i][j]==cmd_comparand[j]. An all-zero mask matches every cell.
- FSM states:
  - IDLE: cmd_ready=1. On a handshake, latch op/comparand/mask and go to EXEC.
  - EXEC: one cycle. Apply the operation to storage and tags. Register rsp_data/rsp_some/rsp_count computed from the post-operation tags and storage. Go to RESP.
  - RESP: rsp_valid=1. Response fields are held stable. On rsp_ready, go to IDLE.
- Empty cases:
  - READ with no tags gives rsp_data=0, rsp_some=0, rsp_count=0.
  - WRITE with no tags changes nothing.
  - SELECT_FIRST with no tags leaves tags at 0.
- rsp_data for a WRITE reflects the newly written words.

## Timing
- Reset values:
  - state IDLE, so cmd_ready=1.
  - rsp_valid=0.
  - rsp_data=0, rsp_some=0, rsp_count=0.
  - tags=0; all storage=0.
- Latency: command accepted at edge N. Storage and tags update at edge N+1. rsp_valid is high from edge N+1 onward.
- Throughput: at most one command per 3 cycles with rsp_ready tied high. Commands never overlap.
- cmd_ready is low in EXEC and RESP. cmd_valid in those states is ignored and must be held by the producer.
- rsp_valid holds with stable data until rsp_ready. Back-to-back cycles with rsp_ready=0 are legal indefinitely.
- The same-edge pair rsp_ready + next cmd_valid is not accepted. The next command is accepted the cycle after returning to IDLE.
- RST_N asserted in any state: immediately return to IDLE and clear storage, tags and response. Any pending response is dropped, not replayed.
- No combinational path from cmd_* to rsp_* or from rsp_ready to cmd_ready.

## Configuration
- CAPP_RESP_COUNT_EN defined: rsp_count is the registered popcount of tags after the operation.
- CAPP_RESP_COUNT_EN undefined: popcount logic is omitted and rsp_count is tied to 0. rsp_some is still computed, and the port list is unchanged.

## Structure
- Package capp_pkg holds:
  - capp_op_e, the 3-bit opcode enum, with the values above.
  - the FSM state enum {IDLE, EXEC, RESP}.
- Sub-module capp_first_responder (NUM_CELLS): combinational priority resolver mapping a tag vector to a one-hot-or-zero vector (lowest index wins). It is used by SELECT_FIRST.

## Test plan
- Reset, then SET_ALL followed by WRITE comparand=0xA5A5A5A5 mask=all-ones, then READ. Required: rsp_data=0xA5A5A5A5, rsp_some=1, rsp_count=NUM_CELLS (0 without macro).
- CLEAR_TAGS, then SEARCH mask=0 → rsp_count=NUM_CELLS. Write cells 3 and 7 to 0x1 via tag setup, then SEARCH comparand=0x1 mask=0x1 → tags exactly {3,7}, rsp_count=2.
- With tags {3,7}: SELECT_FIRST → tags={3}, rsp_count=1. Repeat on empty tags → tags=0, rsp_some=0.
- WRITE comparand=0xFFFF0000 mask=0x00FF00FF on tagged cell 3 holding 0x12345678. Required: READ gives 0x12FF5600, and untagged cells are unchanged.
- Hold rsp_ready=0 for 10 cycles in RESP. Required: rsp_valid and data stable, cmd_ready=0, and a second cmd_valid is not accepted until one cycle after rsp_ready.
- Assert RST_N=0 during EXEC of a WRITE. Required: rsp_valid=0, tags=0, READ after reset returns 0.
